// File: rtl/multicycle_alu.sv
// multicycle_alu: registered execute-stage ALU for the multicycle RV32 core.
// Base integer ops complete in one cycle; RV32M multiply/divide run through
// a fixed-latency iterative unit (shift-add multiply, restoring divide),
// one bit per clock, followed by a single sign-fix cycle.
module multicycle_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            m_ext,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] out
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state_r;
    state_t state_s;

    logic [SHW-1:0]    cnt_r;
    logic [2*XLEN-1:0] acc_r;     // mul: product; div: {remainder, quotient}
    logic [XLEN-1:0]   mcand_r;   // mul: multiplicand magnitude; div: divisor magnitude
    logic [2:0]        f3_r;
    logic              neg_r;     // negate the selected result in FIX
    logic              busy_r;
    logic              done_r;
    logic [XLEN-1:0]   out_r;

    logic              accept_s;
    logic [SHW-1:0]    shamt_s;
    logic [XLEN-1:0]   base_s;

    logic [2:0]        f3_s;
    logic              sa_s;
    logic              sb_s;
    logic              bzero_s;
    logic [XLEN-1:0]   mag_a_s;
    logic [XLEN-1:0]   mag_b_s;
    logic              neg_s;

    logic [XLEN:0]     mul_sum_s;
    logic [2*XLEN-1:0] mul_next_s;
    logic [XLEN:0]     div_shift_s;
    logic [XLEN+1:0]   div_diff_s;
    logic              div_ge_s;
    logic [2*XLEN-1:0] div_next_s;

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   fix_s;

    assign busy     = busy_r;
    assign done     = done_r;
    assign out      = out_r;
    assign accept_s = start && (state_r == IDLE);
    assign shamt_s  = b[SHW-1:0];

    // Single-cycle base integer result, computed from the live operands.
    always_comb begin
        base_s = {XLEN{1'b0}};
        case (op)
            4'd0:    base_s = a + b;
            4'd8:    base_s = a - b;
            4'd6:    base_s = a | b;
            4'd7:    base_s = a & b;
            4'd4:    base_s = a ^ b;
            4'd1:    base_s = a << shamt_s;
            4'd5:    base_s = a >> shamt_s;
            4'd13:   base_s = $signed(a) >>> shamt_s;
            4'd2:    base_s = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd3:    base_s = {{(XLEN-1){1'b0}}, (a < b)};
            4'd9:    base_s = a;
            default: base_s = {XLEN{1'b0}};
        endcase
    end

    // Operand magnitudes and result sign for an M op, decided at acceptance.
    always_comb begin
        f3_s    = op[2:0];
        sa_s    = a[XLEN-1] & ((f3_s == 3'd1) || (f3_s == 3'd2) ||
                               (f3_s == 3'd4) || (f3_s == 3'd6));
        sb_s    = b[XLEN-1] & ((f3_s == 3'd1) || (f3_s == 3'd4) || (f3_s == 3'd6));
        bzero_s = (b == {XLEN{1'b0}});
        mag_a_s = sa_s ? ({XLEN{1'b0}} - a) : a;
        mag_b_s = sb_s ? ({XLEN{1'b0}} - b) : b;
        neg_s   = 1'b0;
        if (f3_s[2] == 1'b0) begin
            neg_s = sa_s ^ sb_s;
        end else if (f3_s[1] == 1'b0) begin
            // Division by zero keeps the all-ones quotient un-negated.
            neg_s = (sa_s ^ sb_s) & ~bzero_s;
        end else begin
            // Remainder takes the dividend's sign.
            neg_s = sa_s;
        end
    end

    // One shift-add multiply step and one restoring divide step.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} +
                      {1'b0, (acc_r[0] ? mcand_r : {XLEN{1'b0}})};
        mul_next_s  = {mul_sum_s, acc_r[XLEN-1:1]};
        div_shift_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, mcand_r};
        div_ge_s    = ~div_diff_s[XLEN+1];
        div_next_s  = {(div_ge_s ? div_diff_s[XLEN-1:0] : div_shift_s[XLEN-1:0]),
                       acc_r[XLEN-2:0], div_ge_s};
    end

    // Sign correction and result selection for the FIX cycle.
    always_comb begin
        prod_s = neg_r ? ({(2*XLEN){1'b0}} - acc_r) : acc_r;
        quot_s = neg_r ? ({XLEN{1'b0}} - acc_r[XLEN-1:0]) : acc_r[XLEN-1:0];
        rem_s  = neg_r ? ({XLEN{1'b0}} - acc_r[2*XLEN-1:XLEN]) : acc_r[2*XLEN-1:XLEN];
        fix_s  = {XLEN{1'b0}};
        case (f3_r)
            3'd0:    fix_s = prod_s[XLEN-1:0];
            3'd1:    fix_s = prod_s[2*XLEN-1:XLEN];
            3'd2:    fix_s = prod_s[2*XLEN-1:XLEN];
            3'd3:    fix_s = prod_s[2*XLEN-1:XLEN];
            3'd4:    fix_s = quot_s;
            3'd5:    fix_s = quot_s;
            3'd6:    fix_s = rem_s;
            3'd7:    fix_s = rem_s;
            default: fix_s = {XLEN{1'b0}};
        endcase
    end

    // Next-state logic: M ops walk IDLE -> ITER (XLEN edges) -> FIX -> IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && m_ext) begin
                    state_s = ITER;
                end else begin
                    state_s = IDLE;
                end
            end
            ITER: begin
                if (cnt_r == SHW'(XLEN - 1)) begin
                    state_s = FIX;
                end else begin
                    state_s = ITER;
                end
            end
            FIX:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= {SHW{1'b0}};
            acc_r   <= {(2*XLEN){1'b0}};
            mcand_r <= {XLEN{1'b0}};
            f3_r    <= 3'd0;
            neg_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            out_r   <= {XLEN{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (m_ext) begin
                            f3_r   <= f3_s;
                            neg_r  <= neg_s;
                            cnt_r  <= {SHW{1'b0}};
                            busy_r <= 1'b1;
                            if (f3_s[2]) begin
                                acc_r   <= {{XLEN{1'b0}}, mag_a_s};
                                mcand_r <= mag_b_s;
                            end else begin
                                acc_r   <= {{XLEN{1'b0}}, mag_b_s};
                                mcand_r <= mag_a_s;
                            end
                        end else begin
                            out_r  <= base_s;
                            done_r <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    acc_r <= f3_r[2] ? div_next_s : mul_next_s;
                    cnt_r <= cnt_r + {{(SHW-1){1'b0}}, 1'b1};
                end
                FIX: begin
                    out_r  <= fix_s;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: a scoreboard queue holds the
// expected result, done cycle and busy-cycle count of every accepted op.
module tb_multicycle_alu;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        m_ext;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] out;

    logic        start64;
    logic        m_ext64;
    logic [3:0]  op64;
    logic [63:0] a64;
    logic [63:0] b64;
    logic        busy64;
    logic        done64;
    logic [63:0] out64;

    typedef struct {
        string       tag;
        logic [31:0] exp;
        int unsigned cyc;
        int unsigned bcnt;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc;
    int unsigned busy_cnt;
    int          n_checks;
    int          n_fail;

    multicycle_alu #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .m_ext(m_ext), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .out(out)
    );

    multicycle_alu #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .start(start64), .m_ext(m_ext64), .op(op64),
        .a(a64), .b(b64), .busy(busy64), .done(done64), .out(out64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: compare every done pulse with the oldest entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt = busy_cnt + 1;
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("spurious_done", 64'(done), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check(e.tag, 64'(out), 64'(e.exp));
                    check({e.tag, "_lat"}, 64'(cyc), 64'(e.cyc));
                    check({e.tag, "_busy"}, 64'(busy_cnt), 64'(e.bcnt));
                end
                busy_cnt = 0;
            end
        end
    end

    // Drive one op at the current negedge, record its expectation, then
    // scramble the operands so late operand changes are exercised.
    task automatic issue(input logic me, input logic [3:0] o, input logic [31:0] aa,
                         input logic [31:0] bb, input logic [31:0] exp, input string tag);
        exp_t e;
        start = 1'b1;
        m_ext = me;
        op    = o;
        a     = aa;
        b     = bb;
        e.tag  = tag;
        e.exp  = exp;
        e.cyc  = cyc + (me ? 32'd34 : 32'd1);
        e.bcnt = me ? 32'd33 : 32'd0;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
        @(negedge clk);
    endtask

    initial begin
        int n;
        int unsigned t0;
        cyc = 0; busy_cnt = 0; n_checks = 0; n_fail = 0;
        rst_n = 1'b0; start = 1'b0; m_ext = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
        start64 = 1'b0; m_ext64 = 1'b0; op64 = 4'd0; a64 = 64'd0; b64 = 64'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_out", 64'(out), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Base sweep.
        issue(1'b0, 4'd0,  32'h8000_0010, 32'h4, 32'h8000_0014, "add");
        issue(1'b0, 4'd8,  32'h8000_0010, 32'h4, 32'h8000_000C, "sub");
        issue(1'b0, 4'd13, 32'h8000_0010, 32'h4, 32'hF800_0001, "sra");
        issue(1'b0, 4'd5,  32'h8000_0010, 32'h4, 32'h0800_0001, "srl");
        issue(1'b0, 4'd2,  32'h8000_0010, 32'h4, 32'h0000_0001, "slt");
        issue(1'b0, 4'd3,  32'h8000_0010, 32'h4, 32'h0000_0000, "sltu");
        issue(1'b0, 4'd1,  32'h8000_0010, 32'h4, 32'h0000_0100, "sll");
        issue(1'b0, 4'd6,  32'h8000_0010, 32'h4, 32'h8000_0014, "or");
        issue(1'b0, 4'd7,  32'h8000_0010, 32'h4, 32'h0000_0000, "and");
        issue(1'b0, 4'd4,  32'h8000_0011, 32'h5, 32'h8000_0014, "xor");
        issue(1'b0, 4'd15, 32'h8000_0010, 32'h4, 32'h0000_0000, "undef");
        issue(1'b0, 4'd9,  32'h8000_0010, 32'h4, 32'h8000_0010, "lui");
        wait_idle();

        // Reset in the middle of a multiply.
        start = 1'b1; m_ext = 1'b1; op = 4'd0; a = 32'd3; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_out", 64'(out), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // Multiply.
        issue(1'b1, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul");
        wait_idle();
        issue(1'b1, 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh");
        wait_idle();
        issue(1'b1, 4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
        wait_idle();
        issue(1'b1, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
        wait_idle();
        issue(1'b1, 4'd0, 32'd1000, 32'd3000, 32'd3000000, "mul_small");
        wait_idle();

        // Divide corners.
        issue(1'b1, 4'd5, 32'd7, 32'd0, 32'hFFFF_FFFF, "divu_z");
        wait_idle();
        issue(1'b1, 4'd7, 32'd7, 32'd0, 32'd7, "remu_z");
        wait_idle();
        issue(1'b1, 4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        wait_idle();
        issue(1'b1, 4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf");
        wait_idle();
        issue(1'b1, 4'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_neg");
        wait_idle();
        issue(1'b1, 4'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_neg");
        wait_idle();
        issue(1'b1, 4'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, "div_z");
        wait_idle();
        issue(1'b1, 4'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, "rem_z");
        wait_idle();

        // Start while busy is ignored; then an add in the done cycle.
        issue(1'b1, 4'd5, 32'd100, 32'd7, 32'd14, "divu_busy");
        repeat (5) @(negedge clk);
        start = 1'b1; m_ext = 1'b1; op = 4'd5; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        issue(1'b0, 4'd0, 32'd3, 32'd4, 32'd7, "add_in_done");
        issue(1'b1, 4'd7, 32'd100, 32'd7, 32'd2, "remu_b2b");
        wait_idle();

        // 64-bit build.
        start64 = 1'b1; m_ext64 = 1'b1; op64 = 4'd3;
        a64 = 64'hFFFF_FFFF_FFFF_FFFF; b64 = 64'hFFFF_FFFF_FFFF_FFFF;
        t0 = cyc;
        @(negedge clk);
        start64 = 1'b0; a64 = 64'd0; b64 = 64'd0;
        n = 0;
        while (!done64 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mulhu64", out64, 64'hFFFF_FFFF_FFFF_FFFE);
        check("mulhu64_lat", 64'(cyc - t0), 64'd66);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
